switch_1x4: RTL and testbench
=============================

Name: switch_1x4

Overview:
- 1-input, 4-output byte-stream packet switch.
- Packets arrive on an 8-bit input qualified by data_status. Each packet is routed by its destination-address byte to one of four output ports, based on four software-programmable port-address registers.
- Each output port has its own FIFO that is drained by a ready/read handshake.
- The block sits between the packet source, the configuration (memory) bus and four packet sinks.

Parameters:
- DW, 8, data/byte width
- FIFO_DEPTH, 64, bytes per output FIFO (power of 2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- data_status  in  1  high while packet bytes are valid on data
- data  in  DW  packet byte stream
- mem_en  in  1  config access enable
- mem_rd_wr  in  1  1 = write, 0 = read (no effect)
- mem_add  in  2  config register index 0..3
- mem_data  in  DW  config write data
- port0..port3  out  DW  output byte per port
- ready_0..ready_3  out  1  port FIFO not empty
- read_0..read_3  in  1  sink pops one byte

Behaviour:
- Reset (asynchronous, active-high):
  - clears all four FIFOs and pointers, the input FSM (to IDLE) and all config registers (to 0x00).
  - drives port0..3 = 0 and ready_0..3 = 0.
  - Reset asserted mid-packet discards the packet.
- Config registers:
  - At a rising edge with mem_en=1 and mem_rd_wr=1, addr_reg[mem_add] <= mem_data.
  - mem_en=1 with mem_rd_wr=0 does nothing (no read-back path).
  - Writes are accepted at any time, but the new value affects only packets whose first byte arrives after the write edge.
- Packet format:
  - Byte 0 = DA, byte 1 = SA, byte 2 = LEN, then LEN payload bytes, then 1 FCS byte.
  - data_status stays high for all bytes contiguously.
  - FCS and LEN are not checked; the packet ends when data_status falls.
- Input FSM:
  - IDLE: on data_status=1, compare data with addr_reg[0..3].
    - If there is a match, select the lowest matching index i, write the DA byte to FIFO i and go to FWD.
    - If there is no match, go to DROP.
  - FWD: each cycle with data_status=1, write data to FIFO i. On data_status=0, go to IDLE.
  - DROP: discard bytes until data_status=0, then go to IDLE.
  - Back-to-back packets need at least one cycle of data_status=0 between them.
- FIFO write: a byte is written only if its FIFO is not full. Bytes arriving when the FIFO is full are silently discarded, and the rest of that packet is still written if space frees up.
- Output handshake, per port:
  - ready_i = (FIFO i not empty), updated combinationally from the pointers.
  - A rising edge with read_i=1 and ready_i=1 pops one byte; port_i shows that byte from the edge onward (registered, 1-cycle latency) and holds it until the next pop.
  - read_i while the FIFO is empty is ignored, and port_i holds its value.
  - Holding read_i high continuously drains one byte per cycle.
- Simultaneous push and pop on the same FIFO are both performed, and the count is unchanged. Full and empty are derived from extra-bit wrap-around pointers.
- Ports are independent; all four may pop in the same cycle.

Test Plan:
- Config write and basic route: write addr_reg 0..3 = 0x11, 0x22, 0x33, 0x44; send packet DA=0x22, SA=0x55, LEN=3, payload 0xA1 0xA2 0xA3, FCS 0x5C -> ready_1 rises after the first byte. Reading 7 bytes yields 22 55 03 A1 A2 A3 5C on port1; ready_1 falls after the last pop; the other ready signals stay 0.
- Unmatched DA: send a packet with DA=0x99 -> all ready signals stay 0, and the next matching packet routes normally.
- All ports: send one packet to each of 0x11, 0x22, 0x33 and 0x44 -> each port receives exactly its own bytes in order; reading all four simultaneously works.
- Reprogram mid-packet: during a packet to 0x33, write addr_reg2 = 0x77 -> the current packet completes on port2; the next packet with DA=0x33 is dropped and DA=0x77 goes to port2.
- Overflow: send a 70-byte packet to port0 with no reads -> exactly 64 bytes are stored; reading yields the first 64 bytes, then ready_0 = 0.
- Reset mid-operation: assert reset while FIFO0 holds bytes and a packet is streaming -> ready and port outputs read 0 immediately; after release, config reads as 0 (a DA=0x00 packet routes to port0) and no stale data remains.

Source files
------------

// File: rtl/switch_1x4_if.sv
// Bundle of the packet-input, configuration-bus and four output-port
// handshake signals of the 1x4 packet switch.
// The master side is the environment: packet source, config bus and sinks.
// The slave side is the switch itself.
interface switch_1x4_if #(
    parameter int DW = 8
);
    // Packet input
    logic          data_status;
    logic [DW-1:0] data;

    // Configuration bus (write-only)
    logic          mem_en;
    logic          mem_rd_wr;
    logic [1:0]    mem_add;
    logic [DW-1:0] mem_data;

    // Output ports
    logic [DW-1:0] port0;
    logic [DW-1:0] port1;
    logic [DW-1:0] port2;
    logic [DW-1:0] port3;
    logic          ready_0;
    logic          ready_1;
    logic          ready_2;
    logic          ready_3;
    logic          read_0;
    logic          read_1;
    logic          read_2;
    logic          read_3;

    modport master (
        output data_status, data,
        output mem_en, mem_rd_wr, mem_add, mem_data,
        output read_0, read_1, read_2, read_3,
        input  port0, port1, port2, port3,
        input  ready_0, ready_1, ready_2, ready_3
    );

    modport slave (
        input  data_status, data,
        input  mem_en, mem_rd_wr, mem_add, mem_data,
        input  read_0, read_1, read_2, read_3,
        output port0, port1, port2, port3,
        output ready_0, ready_1, ready_2, ready_3
    );
endinterface

// File: rtl/switch_1x4.sv
// 1-input, 4-output byte-stream packet switch.
// The DA byte of each packet is matched against four programmable port
// addresses. The lowest matching port receives the whole packet in its FIFO.
// A packet that matches no port is dropped.
// Each output FIFO is drained by its own ready/read handshake with a
// registered output byte.
module switch_1x4 #(
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 64
) (
    input logic         clk,
    input logic         reset,
    switch_1x4_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state;
    logic [1:0]    sel;

    logic [DW-1:0] addr_reg [4];

    // Pointers carry one extra bit so that full and empty can be told apart.
    logic [AW:0]   wr_ptr [4];
    logic [AW:0]   rd_ptr [4];
    logic [DW-1:0] fifo_mem [4][FIFO_DEPTH];
    logic [DW-1:0] port_q [4];

    logic          match_hit;
    logic [1:0]    match_idx;
    logic [3:0]    read_req;
    logic [3:0]    empty;
    logic [3:0]    full;
    logic [3:0]    push_req;
    logic [3:0]    push;
    logic [3:0]    pop;

    assign read_req = {bus.read_3, bus.read_2, bus.read_1, bus.read_0};

    // Find the lowest-index port address equal to the current input byte.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no latch is inferred.
        match_hit = 1'b0;
        match_idx = 2'd0;
        // Scanning from the top down lets the lowest matching index win.
        for (int i = 3; i >= 0; i--) begin
            if (bus.data == addr_reg[i]) begin
                match_hit = 1'b1;
                match_idx = i[1:0];
            end
        end
    end

    // Derive the FIFO status flags from the wrap-around pointers.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                       (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
        end
    end

    // Select which FIFO the current input byte goes to, if any.
    always_comb begin
        push_req = '0;
        if (bus.data_status) begin
            case (state)
                IDLE:    if (match_hit) push_req[match_idx] = 1'b1;
                FWD:     push_req[sel] = 1'b1;
                default: push_req = '0;
            endcase
        end
    end

    // A byte that arrives while its FIFO is full is discarded.
    assign push = push_req & ~full;
    assign pop  = read_req & ~empty;

    // Config register writes. A write on the same edge as a packet's DA byte
    // does not affect that packet, because the match uses the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                addr_reg[i] <= '0;
            end
        end else if (bus.mem_en && bus.mem_rd_wr) begin
            // NOTE: sequential state uses non-blocking assignments only.
            addr_reg[bus.mem_add] <= bus.mem_data;
        end
    end

    // Input FSM: the destination port is latched at the DA byte and held to packet end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sel   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.data_status) begin
                        if (match_hit) begin
                            state <= FWD;
                            sel   <= match_idx;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                FWD:     if (!bus.data_status) state <= IDLE;
                DROP:    if (!bus.data_status) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage writes.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the pointer reset alone makes each FIFO empty.
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                fifo_mem[i][wr_ptr[i][AW-1:0]] <= bus.data;
            end
        end
    end

    // Pointer updates and the registered output byte for each port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                port_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + (AW+1)'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + (AW+1)'(1);
                    port_q[i] <= fifo_mem[i][rd_ptr[i][AW-1:0]];
                end
            end
        end
    end

    assign bus.port0   = port_q[0];
    assign bus.port1   = port_q[1];
    assign bus.port2   = port_q[2];
    assign bus.port3   = port_q[3];
    assign bus.ready_0 = ~empty[0];
    assign bus.ready_1 = ~empty[1];
    assign bus.ready_2 = ~empty[2];
    assign bus.ready_3 = ~empty[3];
endmodule

// File: tb/tb_switch_1x4.sv
// Self-checking bench for switch_1x4.
// A reference model keeps the config table and one byte queue per port.
// Packets are routed by DA lookup at the first byte and capped at 64 queued bytes.
module tb_switch_1x4;
    localparam int DEPTH = 64;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    switch_1x4_if #(.DW(8)) bus ();

    switch_1x4 #(.DW(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [7:0] cfg [4];
    logic [7:0] q [4][$];
    logic [7:0] last_out [4];

    function automatic logic [7:0] port_val(input int p);
        case (p)
            0:       return bus.port0;
            1:       return bus.port1;
            2:       return bus.port2;
            default: return bus.port3;
        endcase
    endfunction

    function automatic logic ready_val(input int p);
        case (p)
            0:       return bus.ready_0;
            1:       return bus.ready_1;
            2:       return bus.ready_2;
            default: return bus.ready_3;
        endcase
    endfunction

    task automatic set_reads(input logic [3:0] m);
        bus.read_0 = m[0];
        bus.read_1 = m[1];
        bus.read_2 = m[2];
        bus.read_3 = m[3];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            cfg[i] = 8'h00;
            q[i].delete();
            last_out[i] = 8'h00;
        end
    endtask

    // Compare every ready flag against the model's queue occupancy.
    task automatic check_ready(input string tag);
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (ready_val(p) !== (q[p].size() != 0)) begin
                errors++;
                $display("FAIL %s ready_%0d got %b exp %b", tag, p, ready_val(p), q[p].size() != 0);
            end
        end
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [7:0] val, input logic wr);
        bus.mem_en    = 1'b1;
        bus.mem_rd_wr = wr;
        bus.mem_add   = idx;
        bus.mem_data  = val;
        @(negedge clk);
        bus.mem_en = 1'b0;
        if (wr) cfg[idx] = val;
    endtask

    // Send one packet. If wr_at >= 0, a config write is issued on that byte's cycle.
    task automatic send_bytes(input logic [7:0] pkt [$], input int wr_at,
                              input logic [1:0] wr_idx, input logic [7:0] wr_val);
        int dest;
        dest = -1;
        for (int i = 3; i >= 0; i--) if (cfg[i] == pkt[0]) dest = i;
        for (int b = 0; b < pkt.size(); b++) begin
            bus.data_status = 1'b1;
            bus.data        = pkt[b];
            if (b == wr_at) begin
                bus.mem_en    = 1'b1;
                bus.mem_rd_wr = 1'b1;
                bus.mem_add   = wr_idx;
                bus.mem_data  = wr_val;
            end
            @(negedge clk);
            bus.mem_en = 1'b0;
            if (b == wr_at) cfg[wr_idx] = wr_val;
            if (dest >= 0 && q[dest].size() < DEPTH) q[dest].push_back(pkt[b]);
            check_ready($sformatf("send_b%0d", b));
        end
        bus.data_status = 1'b0;
        bus.data        = 8'h00;
        @(negedge clk);
    endtask

    task automatic make_pkt(input logic [7:0] da, input int len, output logic [7:0] pkt [$]);
        pkt = {};
        pkt.push_back(da);
        pkt.push_back(8'($urandom));
        pkt.push_back(8'(len));
        for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
        pkt.push_back(8'($urandom));
    endtask

    // One read cycle with mask m; then the outputs are compared with the model.
    task automatic pop_cycle(input logic [3:0] m, input string tag);
        set_reads(m);
        @(negedge clk);
        set_reads(4'b0000);
        for (int p = 0; p < 4; p++) begin
            if (m[p] && q[p].size() > 0) last_out[p] = q[p].pop_front();
            checks++;
            if (port_val(p) !== last_out[p]) begin
                errors++;
                $display("FAIL %s port%0d got %h exp %h", tag, p, port_val(p), last_out[p]);
            end
        end
        check_ready(tag);
    endtask

    task automatic drain_all(input string tag);
        int guard;
        guard = 0;
        while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0 && guard < 300) begin
            pop_cycle(4'b1111, tag);
            guard++;
        end
        checks++;
        if (guard >= 300) begin
            errors++;
            $display("FAIL %s drain timeout got %0d cycles exp <300", tag, guard);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_clear();
        #1;
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (port_val(p) !== 8'h00 || ready_val(p) !== 1'b0) begin
                errors++;
                $display("FAIL reset port%0d got %h/%b exp 00/0", p, port_val(p), ready_val(p));
            end
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_ready("reset_release");
    endtask

    task automatic test_config_route();
        logic [7:0] pkt [$];
        cfg_write(2'd0, 8'h11, 1'b1);
        cfg_write(2'd1, 8'h22, 1'b1);
        cfg_write(2'd2, 8'h33, 1'b1);
        cfg_write(2'd3, 8'h44, 1'b1);
        // A read command must not change anything.
        cfg_write(2'd1, 8'h99, 1'b0);
        pkt = {8'h22, 8'h55, 8'h03, 8'hA1, 8'hA2, 8'hA3, 8'h5C};
        send_bytes(pkt, -1, 2'd0, 8'h00);
        for (int i = 0; i < 7; i++) begin
            pop_cycle(4'b0010, "basic_pop");
            checks++;
            if (bus.port1 !== pkt[i]) begin
                errors++;
                $display("FAIL basic_byte%0d got %h exp %h", i, bus.port1, pkt[i]);
            end
        end
        // Read on an empty FIFO: the port holds its last value.
        pop_cycle(4'b0010, "basic_empty_read");
    endtask

    task automatic test_unmatched();
        logic [7:0] pkt [$];
        make_pkt(8'h99, 4, pkt);
        send_bytes(pkt, -1, 2'd0, 8'h00);
        make_pkt(8'h44, 2, pkt);
        send_bytes(pkt, -1, 2'd0, 8'h00);
        drain_all("unmatched");
    endtask

    task automatic test_all_ports();
        logic [7:0] pkt [$];
        logic [7:0] das [4];
        das = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int p = 0; p < 4; p++) begin
            make_pkt(das[p], 2 + p, pkt);
            send_bytes(pkt, -1, 2'd0, 8'h00);
        end
        drain_all("all_ports");
    endtask

    task automatic test_reprogram();
        logic [7:0] pkt [$];
        make_pkt(8'h33, 5, pkt);
        send_bytes(pkt, 4, 2'd2, 8'h77);
        drain_all("reprog_cur");
        make_pkt(8'h33, 3, pkt);
        send_bytes(pkt, -1, 2'd0, 8'h00);
        make_pkt(8'h77, 3, pkt);
        send_bytes(pkt, -1, 2'd0, 8'h00);
        drain_all("reprog_next");
    endtask

    task automatic test_overflow();
        logic [7:0] pkt [$];
        make_pkt(8'h11, 66, pkt);
        send_bytes(pkt, -1, 2'd0, 8'h00);
        checks++;
        if (q[0].size() != 64) begin
            errors++;
            $display("FAIL overflow model depth got %0d exp 64", q[0].size());
        end
        for (int i = 0; i < 64; i++) begin
            pop_cycle(4'b0001, "overflow_pop");
            checks++;
            if (bus.port0 !== pkt[i]) begin
                errors++;
                $display("FAIL overflow_byte%0d got %h exp %h", i, bus.port0, pkt[i]);
            end
        end
        checks++;
        if (bus.ready_0 !== 1'b0) begin
            errors++;
            $display("FAIL overflow_empty ready_0 got %b exp 0", bus.ready_0);
        end
    endtask

    task automatic test_random();
        logic [7:0] pkt [$];
        logic [7:0] pool [6];
        for (int it = 0; it < 30; it++) begin
            pool = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'($urandom)};
            if ($urandom_range(0, 3) == 0)
                cfg_write(2'($urandom_range(0, 3)), pool[$urandom_range(0, 5)], 1'b1);
            make_pkt(pool[$urandom_range(0, 5)], $urandom_range(0, 6), pkt);
            send_bytes(pkt, -1, 2'd0, 8'h00);
            for (int k = 0; k < $urandom_range(0, 6); k++)
                pop_cycle(4'($urandom), "random_pop");
        end
        drain_all("random_drain");
    endtask

    task automatic test_reset_mid();
        logic [7:0] pkt [$];
        cfg_write(2'd0, 8'h11, 1'b1);
        make_pkt(8'h11, 3, pkt);
        send_bytes(pkt, -1, 2'd0, 8'h00);
        // Stream part of a second packet, then reset asynchronously.
        make_pkt(8'h11, 8, pkt);
        for (int b = 0; b < 3; b++) begin
            bus.data_status = 1'b1;
            bus.data        = pkt[b];
            @(negedge clk);
        end
        #2 reset = 1'b1;
        model_clear();
        #1;
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (port_val(p) !== 8'h00 || ready_val(p) !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid port%0d got %h/%b exp 00/0", p, port_val(p), ready_val(p));
            end
        end
        bus.data_status = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_ready("reset_mid_release");
        // Config is all zero, so DA=0x00 goes to port 0.
        make_pkt(8'h00, 2, pkt);
        send_bytes(pkt, -1, 2'd0, 8'h00);
        checks++;
        if (bus.ready_0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_route ready_0 got %b exp 1", bus.ready_0);
        end
        drain_all("reset_mid_drain");
    endtask

    initial begin
        bus.data_status = 1'b0;
        bus.data        = 8'h00;
        bus.mem_en      = 1'b0;
        bus.mem_rd_wr   = 1'b0;
        bus.mem_add     = 2'd0;
        bus.mem_data    = 8'h00;
        set_reads(4'b0000);
        @(negedge clk);
        test_reset();
        test_config_route();
        test_unmatched();
        test_all_ports();
        test_reprogram();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
